// File: rtl/gate_label_sequencer_pkg.sv
// Shared types and constants for the gate label sequencer and its label store.
// Optional feature macro: GATE_FREE_XOR_EN (free-XOR bypass of the evaluator).
package gate_label_sequencer_pkg;

  localparam int WIRE_ID_W = 13;
  localparam int LABEL_W   = 128;

  localparam logic GATE_AND = 1'b0;
  localparam logic GATE_XOR = 1'b1;

  typedef logic [WIRE_ID_W-1:0] wire_id_t;
  typedef logic [LABEL_W-1:0]   label_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_A    = 4'd1,
    ST_WAIT_A  = 4'd2,
    ST_RD_B    = 4'd3,
    ST_WAIT_B  = 4'd4,
    ST_EVAL    = 4'd5,
    ST_RESULT  = 4'd6,
    ST_WR      = 4'd7,
    ST_WAIT_WR = 4'd8
  } state_t;

  // Free-XOR output label: the XOR of the two input labels.
  function automatic label_t free_xor_label(input label_t a, input label_t b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/gate_label_sequencer_if.sv
// Bus bundle between the gate source, the sequencer, the label store and the
// gate evaluator. master = sequencer view, slave = peer (store/source/evaluator) view.
interface gate_label_sequencer_if;
  import gate_label_sequencer_pkg::*;

  // gate descriptor handshake
  logic     gate_valid;
  logic     gate_ready;
  logic     gate_type;
  wire_id_t gate_in_a;
  wire_id_t gate_in_b;
  wire_id_t gate_out;

  // label_array request/response
  wire_id_t la_wire_id;
  logic     la_id_strobe;
  logic     la_wr_en;
  label_t   la_label_in;
  label_t   la_label_out;
  logic     la_done;

  // evaluator input labels
  logic     eval_valid;
  logic     eval_ready;
  label_t   eval_label_a;
  label_t   eval_label_b;

  // evaluator result
  logic     res_valid;
  logic     res_ready;
  label_t   res_label;

  modport master (
    input  gate_valid, gate_type, gate_in_a, gate_in_b, gate_out,
    output gate_ready,
    output la_wire_id, la_id_strobe, la_wr_en, la_label_in,
    input  la_label_out, la_done,
    output eval_valid, eval_label_a, eval_label_b,
    input  eval_ready,
    input  res_valid, res_label,
    output res_ready
  );

  modport slave (
    output gate_valid, gate_type, gate_in_a, gate_in_b, gate_out,
    input  gate_ready,
    input  la_wire_id, la_id_strobe, la_wr_en, la_label_in,
    output la_label_out, la_done,
    input  eval_valid, eval_label_a, eval_label_b,
    output eval_ready,
    output res_valid, res_label,
    input  res_ready
  );

endinterface

// File: rtl/label_array.sv
// Wire-label store: 8192 x 128-bit labels. A request is taken on la_id_strobe;
// write data is sampled over the two cycles after the strobe (low half, then
// high half) and la_done pulses 4 cycles after the strobe.
module label_array
  import gate_label_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  gate_label_sequencer_if.slave bus
);

  localparam int HALF_W = LABEL_W / 2;

  label_t              r_mem [0:(1 << WIRE_ID_W) - 1];
  logic                r_active;
  logic [1:0]          r_cnt;
  logic                r_we;
  wire_id_t            r_id;
  logic [HALF_W-1:0]   r_lo;
  logic [HALF_W-1:0]   r_hi;
  logic                r_done;
  label_t              r_rdata;

  assign bus.la_done      = r_done;
  assign bus.la_label_out = r_rdata;

  // Request tracking: latch address/direction, gather write halves, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= 2'd0;
      r_we     <= 1'b0;
      r_id     <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_active && bus.la_id_strobe) begin
        r_active <= 1'b1;
        r_cnt    <= 2'd0;
        r_id     <= bus.la_wire_id;
        r_we     <= bus.la_wr_en;
      end else if (r_active) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd0) begin
          r_lo <= bus.la_label_in[HALF_W-1:0];
        end
        if (r_cnt == 2'd1) begin
          r_hi <= bus.la_label_in[LABEL_W-1:HALF_W];
        end
        if (r_cnt == 2'd2) begin
          r_done   <= 1'b1;
          r_active <= 1'b0;
          if (!r_we) begin
            r_rdata <= r_mem[r_id];
          end
        end
      end
    end
  end

  // Storage write, committed in the cycle that raises done.
  always_ff @(posedge clk) begin
    if (r_active && (r_cnt == 2'd2) && r_we) begin
      r_mem[r_id] <= {r_hi, r_lo};
    end
  end

endmodule

// File: rtl/gate_label_sequencer.sv
// Per-gate control stage in front of the wire-label store: reads the two input
// labels of a gate, hands them to the evaluator, and writes the result label
// back at the gate's output wire. Gates are processed strictly one at a time.
// Optional feature macro: GATE_FREE_XOR_EN -- XOR gates bypass the evaluator
// and write label_a ^ label_b directly.
module gate_label_sequencer
  import gate_label_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  gate_label_sequencer_if.master bus,
  output logic                   busy
);

  state_t   r_state;
  logic     r_gate_type;
  wire_id_t r_in_b;
  wire_id_t r_out;
  label_t   r_label_a;

  logic     r_gate_ready;
  wire_id_t r_la_wire_id;
  logic     r_la_strobe;
  logic     r_la_wr_en;
  label_t   r_la_label_in;
  logic     r_eval_valid;
  label_t   r_eval_a;
  label_t   r_eval_b;
  logic     r_res_ready;
  logic     r_busy;

  logic     w_free_xor;

`ifdef GATE_FREE_XOR_EN
  assign w_free_xor = (r_gate_type == GATE_XOR);
`else
  // Every gate goes through the evaluator; the latched type is not consulted.
  assign w_free_xor = r_gate_type & 1'b0;
`endif

  assign bus.gate_ready   = r_gate_ready;
  assign bus.la_wire_id   = r_la_wire_id;
  assign bus.la_id_strobe = r_la_strobe;
  assign bus.la_wr_en     = r_la_wr_en;
  assign bus.la_label_in  = r_la_label_in;
  assign bus.eval_valid   = r_eval_valid;
  assign bus.eval_label_a = r_eval_a;
  assign bus.eval_label_b = r_eval_b;
  assign bus.res_ready    = r_res_ready;
  assign busy             = r_busy;

  // Gate FSM with registered outputs; request fields stay put between a strobe and its done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gate_type   <= GATE_AND;
      r_in_b        <= '0;
      r_out         <= '0;
      r_label_a     <= '0;
      r_gate_ready  <= 1'b0;
      r_la_wire_id  <= '0;
      r_la_strobe   <= 1'b0;
      r_la_wr_en    <= 1'b0;
      r_la_label_in <= '0;
      r_eval_valid  <= 1'b0;
      r_eval_a      <= '0;
      r_eval_b      <= '0;
      r_res_ready   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_la_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_gate_ready && bus.gate_valid) begin
            // Input A's wire id is held in the address register itself.
            r_gate_type  <= bus.gate_type;
            r_in_b       <= bus.gate_in_b;
            r_out        <= bus.gate_out;
            r_gate_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_la_strobe  <= 1'b1;
            r_la_wire_id <= bus.gate_in_a;
            r_la_wr_en   <= 1'b0;
            r_state      <= ST_RD_A;
          end else begin
            r_gate_ready <= 1'b1;
          end
        end
        ST_RD_A: begin
          r_state <= ST_WAIT_A;
        end
        ST_WAIT_A: begin
          if (bus.la_done) begin
            r_label_a    <= bus.la_label_out;
            r_la_strobe  <= 1'b1;
            r_la_wire_id <= r_in_b;
            r_la_wr_en   <= 1'b0;
            r_state      <= ST_RD_B;
          end
        end
        ST_RD_B: begin
          r_state <= ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (bus.la_done) begin
            r_eval_a <= r_label_a;
            r_eval_b <= bus.la_label_out;
            if (w_free_xor) begin
              r_la_label_in <= free_xor_label(r_label_a, bus.la_label_out);
              r_la_strobe   <= 1'b1;
              r_la_wire_id  <= r_out;
              r_la_wr_en    <= 1'b1;
              r_state       <= ST_WR;
            end else begin
              r_eval_valid <= 1'b1;
              r_state      <= ST_EVAL;
            end
          end
        end
        ST_EVAL: begin
          if (bus.eval_ready) begin
            r_eval_valid <= 1'b0;
            r_res_ready  <= 1'b1;
            r_state      <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (bus.res_valid) begin
            r_res_ready   <= 1'b0;
            r_la_label_in <= bus.res_label;
            r_la_strobe   <= 1'b1;
            r_la_wire_id  <= r_out;
            r_la_wr_en    <= 1'b1;
            r_state       <= ST_WR;
          end
        end
        ST_WR: begin
          r_state <= ST_WAIT_WR;
        end
        ST_WAIT_WR: begin
          if (bus.la_done) begin
            r_gate_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_gate_ready <= 1'b0;
          r_eval_valid <= 1'b0;
          r_res_ready  <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_label_sequencer.sv
// Directed bench for gate_label_sequencer with a real label_array behind it.
// Table rows run whole gates through a zero-wait evaluator; hand sequences
// cover evaluator back-pressure and a reset in the middle of a gate.
module tb_gate_label_sequencer;
  import gate_label_sequencer_pkg::*;

  logic clk;
  logic rst;
  logic busy;

  gate_label_sequencer_if bus();

  gate_label_sequencer u_dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  label_array u_la (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // results of the most recent run_gate
  int     g_timeout, g_t_rd_a, g_t_eval, g_period, g_strobes;
  int     g_saw_eval, g_id_err, g_hold_err, g_stab_err;
  label_t g_lab_a, g_lab_b, g_wr_lbl;

  typedef struct {
    logic     typ;
    wire_id_t a;
    wire_id_t b;
    wire_id_t o;
    label_t   res;
    logic     chk_lab;
    label_t   exp_a;
    label_t   exp_b;
    label_t   exp_wr;
    int       exp_period;
    int       exp_eval;
  } vec_t;

  vec_t tbl [8];

  function automatic label_t rep(input logic [7:0] x);
    return {16{x}};
  endfunction

  function automatic vec_t mk(input logic typ, input wire_id_t a, input wire_id_t b,
                              input wire_id_t o, input label_t res, input logic chk_lab,
                              input label_t ea, input label_t eb, input label_t ewr,
                              input int per, input int ev);
    vec_t v;
    v.typ = typ; v.a = a; v.b = b; v.o = o; v.res = res; v.chk_lab = chk_lab;
    v.exp_a = ea; v.exp_b = eb; v.exp_wr = ewr; v.exp_period = per; v.exp_eval = ev;
    return v;
  endfunction

  task automatic chk(input string name, input label_t act, input label_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one gate and act as evaluator; ew/rw are the wait cycles before
  // eval_ready / res_valid. Cycle 0 is the acceptance cycle.
  task automatic run_gate(input logic typ, input wire_id_t a, input wire_id_t b,
                          input wire_id_t o, input label_t res, input int ew, input int rw);
    int       k, ev_cnt, rs_cnt, w;
    logic     holding, fin;
    wire_id_t h_id;
    logic     h_we;
    label_t   h_lbl;
    g_timeout = 0; g_t_rd_a = -1; g_t_eval = -1; g_period = -1; g_strobes = 0;
    g_saw_eval = 0; g_id_err = 0; g_hold_err = 0; g_stab_err = 0;
    g_lab_a = '0; g_lab_b = '0; g_wr_lbl = '0;
    ev_cnt = 0; rs_cnt = 0; holding = 1'b0; fin = 1'b0;
    h_id = '0; h_we = 1'b0; h_lbl = '0;
    w = 0;
    while (!bus.gate_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.gate_ready) begin
      g_timeout = 1;
      return;
    end
    bus.gate_valid = 1'b1;
    bus.gate_type  = typ;
    bus.gate_in_a  = a;
    bus.gate_in_b  = b;
    bus.gate_out   = o;
    k = 0;
    while (!fin && k < 200) begin
      @(negedge clk);
      k++;
      bus.gate_valid = 1'b0;
      if (bus.la_id_strobe) begin
        g_strobes++;
        if (g_strobes == 1) g_t_rd_a = k;
        case (g_strobes)
          1: if (bus.la_wire_id !== a || bus.la_wr_en !== 1'b0) g_id_err++;
          2: if (bus.la_wire_id !== b || bus.la_wr_en !== 1'b0) g_id_err++;
          3: begin
            if (bus.la_wire_id !== o || bus.la_wr_en !== 1'b1) g_id_err++;
            g_wr_lbl = bus.la_label_in;
          end
          default: g_id_err++;
        endcase
        holding = 1'b1;
        h_id = bus.la_wire_id; h_we = bus.la_wr_en; h_lbl = bus.la_label_in;
      end else if (holding) begin
        if (bus.la_wire_id !== h_id || bus.la_wr_en !== h_we || bus.la_label_in !== h_lbl)
          g_hold_err++;
        if (bus.la_done) holding = 1'b0;
      end
      if (bus.eval_valid && g_saw_eval == 0) begin
        g_saw_eval = 1;
        g_t_eval = k;
        g_lab_a = bus.eval_label_a;
        g_lab_b = bus.eval_label_b;
      end else if (g_saw_eval != 0) begin
        if (bus.eval_label_a !== g_lab_a || bus.eval_label_b !== g_lab_b) g_stab_err++;
      end
      if (bus.eval_valid) begin
        bus.eval_ready = (ev_cnt >= ew);
        ev_cnt++;
      end else begin
        bus.eval_ready = 1'b0;
      end
      if (bus.res_ready) begin
        bus.res_valid = (rs_cnt >= rw);
        bus.res_label = res;
        rs_cnt++;
      end else begin
        bus.res_valid = 1'b0;
      end
      if (k >= 2 && bus.gate_ready) fin = 1'b1;
    end
    g_period = k;
    if (!fin) g_timeout = 1;
    g_lab_a = bus.eval_label_a;
    g_lab_b = bus.eval_label_b;
    bus.eval_ready = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_int({tag, "_gate_ready"}, int'(bus.gate_ready), 0);
    chk_int({tag, "_busy"},       int'(busy), 0);
    chk_int({tag, "_strobe"},     int'(bus.la_id_strobe), 0);
    chk_int({tag, "_wr_en"},      int'(bus.la_wr_en), 0);
    chk_int({tag, "_wire_id"},    int'(bus.la_wire_id), 0);
    chk    ({tag, "_label_in"},   bus.la_label_in, '0);
    chk_int({tag, "_eval_valid"}, int'(bus.eval_valid), 0);
    chk    ({tag, "_eval_a"},     bus.eval_label_a, '0);
    chk    ({tag, "_eval_b"},     bus.eval_label_b, '0);
    chk_int({tag, "_res_ready"},  int'(bus.res_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string nm;
    label_t xor_wr, xor_rd;
    int     xor_per, xor_ev;

    rst = 1'b1;
    bus.gate_valid = 1'b0; bus.gate_type = 1'b0;
    bus.gate_in_a = '0; bus.gate_in_b = '0; bus.gate_out = '0;
    bus.eval_ready = 1'b0; bus.res_valid = 1'b0; bus.res_label = '0;

`ifdef GATE_FREE_XOR_EN
    xor_wr = rep(8'h33); xor_per = 16; xor_ev = 0;
`else
    xor_wr = rep(8'h88); xor_per = 18; xor_ev = 1;
`endif
    xor_rd = xor_wr;

    tbl[0] = mk(GATE_AND, 13'd0,    13'd0,    13'd5,    rep(8'h11), 1'b0, '0, '0, rep(8'h11), 18, 1);
    tbl[1] = mk(GATE_AND, 13'd0,    13'd0,    13'd6,    rep(8'h22), 1'b0, '0, '0, rep(8'h22), 18, 1);
    tbl[2] = mk(GATE_AND, 13'd5,    13'd6,    13'd7,    rep(8'hAB), 1'b1, rep(8'h11), rep(8'h22), rep(8'hAB), 18, 1);
    tbl[3] = mk(GATE_AND, 13'd7,    13'd7,    13'd8,    rep(8'h44), 1'b1, rep(8'hAB), rep(8'hAB), rep(8'h44), 18, 1);
    tbl[4] = mk(GATE_AND, 13'd5,    13'd6,    13'd8191, rep(8'h66), 1'b1, rep(8'h11), rep(8'h22), rep(8'h66), 18, 1);
    tbl[5] = mk(GATE_AND, 13'd8191, 13'd8191, 13'd9,    rep(8'h77), 1'b1, rep(8'h66), rep(8'h66), rep(8'h77), 18, 1);
    tbl[6] = mk(GATE_XOR, 13'd5,    13'd6,    13'd10,   rep(8'h88), 1'b1, rep(8'h11), rep(8'h22), xor_wr, xor_per, xor_ev);
    tbl[7] = mk(GATE_AND, 13'd10,   13'd9,    13'd12,   rep(8'h99), 1'b1, xor_rd, rep(8'h77), rep(8'h99), 18, 1);

    // reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_int("rst_gate_ready_after", int'(bus.gate_ready), 1);

    for (int i = 0; i < 8; i++) begin
      run_gate(tbl[i].typ, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].res, 0, 0);
      nm = $sformatf("row%0d", i);
      chk_int({nm, "_timeout"}, g_timeout, 0);
      chk_int({nm, "_rd_a_cycle"}, g_t_rd_a, 1);
      chk_int({nm, "_period"}, g_period, tbl[i].exp_period);
      chk_int({nm, "_strobes"}, g_strobes, 3);
      chk_int({nm, "_eval_seen"}, g_saw_eval, tbl[i].exp_eval);
      if (tbl[i].exp_eval != 0) chk_int({nm, "_eval_cycle"}, g_t_eval, 11);
      chk_int({nm, "_id_err"}, g_id_err, 0);
      chk_int({nm, "_hold_err"}, g_hold_err, 0);
      chk_int({nm, "_stab_err"}, g_stab_err, 0);
      chk({nm, "_wr_label"}, g_wr_lbl, tbl[i].exp_wr);
      if (tbl[i].chk_lab) begin
        chk({nm, "_label_a"}, g_lab_a, tbl[i].exp_a);
        chk({nm, "_label_b"}, g_lab_b, tbl[i].exp_b);
      end
    end

    // eval_ready held low for 10 cycles
    run_gate(GATE_AND, 13'd5, 13'd6, 13'd13, rep(8'hCC), 10, 0);
    chk_int("evwait_timeout", g_timeout, 0);
    chk_int("evwait_period", g_period, 28);
    chk_int("evwait_eval_cycle", g_t_eval, 11);
    chk_int("evwait_strobes", g_strobes, 3);
    chk_int("evwait_stab_err", g_stab_err, 0);
    chk_int("evwait_hold_err", g_hold_err, 0);
    chk("evwait_label_a", g_lab_a, rep(8'h11));
    chk("evwait_label_b", g_lab_b, rep(8'h22));
    chk("evwait_wr_label", g_wr_lbl, rep(8'hCC));

    // res_valid held low for 10 cycles
    run_gate(GATE_AND, 13'd13, 13'd6, 13'd14, rep(8'hDD), 0, 10);
    chk_int("reswait_timeout", g_timeout, 0);
    chk_int("reswait_period", g_period, 28);
    chk_int("reswait_strobes", g_strobes, 3);
    chk_int("reswait_stab_err", g_stab_err, 0);
    chk_int("reswait_id_err", g_id_err, 0);
    chk("reswait_label_a", g_lab_a, rep(8'hCC));
    chk("reswait_label_b", g_lab_b, rep(8'h22));
    chk("reswait_wr_label", g_wr_lbl, rep(8'hDD));

    // reset asserted while waiting for label B
    bus.gate_valid = 1'b1; bus.gate_type = GATE_AND;
    bus.gate_in_a = 13'd5; bus.gate_in_b = 13'd6; bus.gate_out = 13'd15;
    @(negedge clk);
    bus.gate_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk_int("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk_int("midrst_gate_ready_after", int'(bus.gate_ready), 1);
    chk_int("midrst_busy_after", int'(busy), 0);

    run_gate(GATE_AND, 13'd5, 13'd6, 13'd15, rep(8'hEE), 0, 0);
    chk_int("post_timeout", g_timeout, 0);
    chk_int("post_period", g_period, 18);
    chk_int("post_strobes", g_strobes, 3);
    chk("post_label_a", g_lab_a, rep(8'h11));
    chk("post_label_b", g_lab_b, rep(8'h22));
    chk("post_wr_label", g_wr_lbl, rep(8'hEE));

    run_gate(GATE_AND, 13'd15, 13'd14, 13'd16, rep(8'h01), 0, 0);
    chk_int("readback_timeout", g_timeout, 0);
    chk("readback_label_a", g_lab_a, rep(8'hEE));
    chk("readback_label_b", g_lab_b, rep(8'hDD));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_label_sequencer.md
# gate_label_sequencer

Per-gate control stage directly upstream of the wire-label store. It accepts one gate descriptor at a time, reads the gate's two input labels from `label_array`, and hands them to the gate evaluator. It then writes the evaluator's result label back to `label_array` at the gate's output wire. Gates are processed strictly serially, so a gate may read a wire written by the previous gate with no hazard logic.

## Interface

- No parameters. Widths are fixed: wire id 13 bits, label 128 bits.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `gate_valid` in 1: descriptor present.
- `gate_ready` out 1: sequencer can accept a descriptor.
- `gate_type` in 1: 0 = AND (non-free), 1 = XOR.
- `gate_in_a` in 13: wire id of input A.
- `gate_in_b` in 13: wire id of input B.
- `gate_out` in 13: wire id of the output.
- `la_wire_id` out 13: address to `label_array`.
- `la_id_strobe` out 1: one-cycle request pulse.
- `la_wr_en` out 1: 1 = write, 0 = read.
- `la_label_in` out 128: write data.
- `la_label_out` in 128: read data.
- `la_done` in 1: one-cycle completion pulse.
- `eval_valid` out 1: input labels presented to the evaluator.
- `eval_ready` in 1: evaluator accepts the labels.
- `eval_label_a` out 128: label of input A.
- `eval_label_b` out 128: label of input B.
- `res_valid` in 1: evaluator result present.
- `res_ready` out 1: sequencer accepts the result.
- `res_label` in 128: result label.
- `busy` out 1: high whenever not in IDLE.

## Operation

States and transitions:
- IDLE: `gate_ready`=1. On `gate_valid`, latch `gate_type`, `gate_in_a`, `gate_in_b`, `gate_out`, then go to RD_A.
- RD_A: pulse `la_id_strobe`, with `la_wire_id`=A and `la_wr_en`=0. Go to WAIT_A.
- WAIT_A: on `la_done`, capture `la_label_out` into label A, then go to RD_B.
- RD_B / WAIT_B: same as RD_A / WAIT_A for input B. On `la_done`, capture label B and go to EVAL.
- EVAL: `eval_valid`=1. On `eval_ready`, go to RESULT.
- RESULT: `res_ready`=1. On `res_valid`, latch `res_label` into the write register, then go to WR.
- WR: pulse `la_id_strobe`, with `la_wire_id`=out and `la_wr_en`=1. Go to WAIT_WR.
- WAIT_WR: on `la_done`, go to IDLE.

Rules:
- `la_id_strobe` is asserted only in RD_A, RD_B and WR, for exactly one cycle each.
- `la_wire_id`, `la_wr_en` and `la_label_in` are registered and held stable from the strobe cycle until `la_done`. `label_array` samples write data over two cycles, so this hold is required.
- `eval_label_a` and `eval_label_b` hold their values from the WAIT_B capture until the next gate's capture.
- When A == B, two reads are still issued, and both labels are equal.
- Wire id 8191 needs no special handling.
- The sequencer ignores `la_done` outside the WAIT_* states.
- The sequencer ignores `res_valid` outside RESULT, and `eval_ready` outside EVAL.

Reset values:
- `gate_ready`=0 during reset, then 1 in the cycle after reset deasserts.
- `la_id_strobe`=0, `la_wr_en`=0, `la_wire_id`=0, `la_label_in`=0.
- `eval_valid`=0, `eval_label_a`=0, `eval_label_b`=0.
- `res_ready`=0, `busy`=0.

Reset mid-operation:
- The sequencer returns to IDLE and the in-flight gate is dropped.
- `label_array` shares `rst`, so no orphaned `la_done` arrives.

## Timing

- A gate is accepted at cycle 0; the RD_A strobe occurs at cycle 1.
- `label_array` raises `la_done` 4 cycles after the strobe, so the A capture happens at cycle 5.
- The RD_B strobe occurs at cycle 6; the B capture at cycle 10.
- `eval_valid` goes high at cycle 11.
- With zero-wait `eval_ready` and `res_valid`: EVAL at 11, RESULT at 12, WR strobe at 13, `la_done` at 17, IDLE at 18.
- Minimum gate period with a zero-wait evaluator: 18 cycles.
- Handshakes complete in a cycle where valid and ready are both high.

## Configuration

- `GATE_FREE_XOR_EN` defined: when `gate_type`=1, EVAL and RESULT are skipped.
  - The write register is loaded with `label_a ^ label_b` on the WAIT_B capture, and the FSM goes straight to WR.
  - `eval_valid` never rises for XOR gates.
  - XOR gate period is 16 cycles.
- `GATE_FREE_XOR_EN` undefined: `gate_type` is ignored and every gate goes through the evaluator.

## Structure

- A shared package holds:
  - `WIRE_ID_W`=13 and `LABEL_W`=128.
  - The state enum.
  - The gate-type codes `GATE_AND`=0 and `GATE_XOR`=1.
- Single module, no sub-modules.
- The bench instantiates it together with a real `label_array` instance.

## Test plan

1. Preload wire 5 = 0x11…11 and wire 6 = 0x22…22, then send an AND gate (A=5, B=6, out=7) with an evaluator returning 0xAB…AB. Expect `eval_label_a`=0x11…11, `eval_label_b`=0x22…22, and wire 7 reads back 0xAB…AB.
2. Zero-wait evaluator. Expect the RD_A strobe at cycle 1, `eval_valid` at cycle 11, and `gate_ready` again at cycle 18.
3. With `GATE_FREE_XOR_EN` defined, send an XOR gate on wires 5 and 6. Expect wire 7 = 0x33…33, `eval_valid` never high, and a 16-cycle period.
4. Chain of two gates, where gate 2 reads wire 7 written by gate 1. Expect gate 2 to see gate 1's result label.
5. Hold `eval_ready` low for 10 cycles, and separately hold `res_valid` low for 10 cycles. Expect the labels held stable and no extra strobes.
6. Assert `rst` during WAIT_B. Expect the next cycle in IDLE, all outputs at reset values, and the next gate processed correctly.
